// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the MIPS datapath.
// slave  : the control unit (reads IR fields/hits/flags, drives selects and strobes)
// master : the datapath side (drives IR fields/hits/flags, reads selects and strobes)
interface multicycle_control_unit_if;
  logic [5:0] Instruct;
  logic [5:0] funct;
  logic       ihit;
  logic       dhit;
  logic       zero;
  logic       overflow;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic [1:0] RegDst;
  logic [1:0] ALUSrc;
  logic       ExtOp;
  logic [3:0] ALUop;
  logic       iREN;
  logic       dREN;
  logic       dWEN;
  logic       beq;
  logic       bne;
  logic       jump;
  logic       jal;
  logic       jr;
  logic       lui;
  logic       mem2reg;
  logic       halt;
  logic       mem_err;
  logic [2:0] state_o;

  modport slave (
    input  Instruct, funct, ihit, dhit, zero, overflow,
    output PCWr, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUop, iREN, dREN, dWEN,
           beq, bne, jump, jal, jr, lui, mem2reg, halt, mem_err, state_o
  );

  modport master (
    output Instruct, funct, ihit, dhit, zero, overflow,
    input  PCWr, IRWr, RegWr, RegDst, ALUSrc, ExtOp, ALUop, iREN, dREN, dWEN,
           beq, bne, jump, jal, jr, lui, mem2reg, halt, mem_err, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// cache-hit waits, hit-wait timeout, overflow trap and illegal-opcode halt.
//
// state  | meaning
// FETCH  | icache read, load IR and PC+4 on ihit
// DECODE | resolve J/JAL/HALT/illegal, else go execute
// EXEC   | branches/JR resolve, overflow trap, pick MEM or WB
// MEM    | dcache read (LW) or write (SW) until dhit
// WB     | register file write
// HALT   | parked until reset
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit OVF_TRAP        = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic CLK,
  input logic nRST,
  multicycle_control_unit_if.slave ctl
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                         F_SLTU = 6'h2B;
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  // A zero timeout means "wait forever"; keep the counter at least one bit wide.
  localparam bit         TO_EN   = (MEM_TIMEOUT != 0);
  localparam int         CW      = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          halt_q, err_q, err_set;
  logic          legal, ovf_op, lui_sel, mem_rd, ext_op;
  logic [1:0]    reg_dst, alu_src;
  logic [3:0]    alu_op;
  logic          pc_wr, ir_wr, reg_wr, i_ren, d_ren, d_wen, beq_s, bne_s, jump_s, jal_s, jr_s;
  logic          wait_low;

  // Decode selects follow the IR fields in every state.
  always_comb begin
    legal = 1'b1; ovf_op = 1'b0; lui_sel = 1'b0; mem_rd = 1'b0; ext_op = 1'b0;
    reg_dst = 2'b00; alu_src = 2'b00; alu_op = ALU_ADD;
    case (ctl.Instruct)
      OP_RTYPE: begin
        reg_dst = 2'b01;
        case (ctl.funct)
          F_SLL:  begin alu_op = ALU_SLL; alu_src = 2'b10; end
          F_SRL:  begin alu_op = ALU_SRL; alu_src = 2'b10; end
          F_JR:   alu_op = ALU_ADD;
          F_ADD:  begin alu_op = ALU_ADD; ovf_op = 1'b1; end
          F_ADDU: alu_op = ALU_ADD;
          F_SUB:  begin alu_op = ALU_SUB; ovf_op = 1'b1; end
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_J:     alu_op = ALU_ADD;
      OP_JAL:   reg_dst = 2'b10;
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; ext_op = 1'b1; end
      OP_ADDI:  begin alu_src = 2'b01; ext_op = 1'b1; ovf_op = 1'b1; end
      OP_ADDIU: begin alu_src = 2'b01; ext_op = 1'b1; end
      OP_SLTI:  begin alu_src = 2'b01; ext_op = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU: begin alu_src = 2'b01; ext_op = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin alu_src = 2'b01; alu_op = ALU_AND; end
      OP_ORI:   begin alu_src = 2'b01; alu_op = ALU_OR; end
      OP_XORI:  begin alu_src = 2'b01; alu_op = ALU_XOR; end
      OP_LUI:   begin alu_src = 2'b01; lui_sel = 1'b1; end
      OP_LW:    begin alu_src = 2'b01; ext_op = 1'b1; mem_rd = 1'b1; end
      OP_SW:    begin alu_src = 2'b01; ext_op = 1'b1; end
      OP_HALT:  alu_op = ALU_ADD;
      default:  legal = 1'b0;
    endcase
  end

  // Next state, per-state strobes and timeout detection.
  always_comb begin
    next_state = state; err_set = 1'b0; wait_low = 1'b0;
    pc_wr = 1'b0; ir_wr = 1'b0; reg_wr = 1'b0; i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    beq_s = 1'b0; bne_s = 1'b0; jump_s = 1'b0; jal_s = 1'b0; jr_s = 1'b0;
    case (state)
      S_FETCH: begin
        i_ren = 1'b1;
        if (ctl.ihit) begin
          ir_wr = 1'b1; pc_wr = 1'b1; next_state = S_DECODE;
        end else if (TO_EN && cnt == TO_LAST) begin
          err_set = 1'b1; next_state = S_HALT;
        end else begin
          wait_low = 1'b1;
        end
      end
      S_DECODE: begin
        if (ctl.Instruct == OP_HALT) next_state = S_HALT;
        else if (!legal) next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        else if (ctl.Instruct == OP_J) begin
          jump_s = 1'b1; pc_wr = 1'b1; next_state = S_FETCH;
        end else if (ctl.Instruct == OP_JAL) begin
          jal_s = 1'b1; reg_wr = 1'b1; pc_wr = 1'b1; next_state = S_FETCH;
        end else next_state = S_EXEC;
      end
      S_EXEC: begin
        if (ctl.Instruct == OP_BEQ) begin
          beq_s = 1'b1; pc_wr = ctl.zero; next_state = S_FETCH;
        end else if (ctl.Instruct == OP_BNE) begin
          bne_s = 1'b1; pc_wr = !ctl.zero; next_state = S_FETCH;
        end else if (ctl.Instruct == OP_RTYPE && ctl.funct == F_JR) begin
          jr_s = 1'b1; pc_wr = 1'b1; next_state = S_FETCH;
        end else if (ctl.Instruct == OP_LW || ctl.Instruct == OP_SW) next_state = S_MEM;
        else if (OVF_TRAP && ovf_op && ctl.overflow) next_state = S_HALT;
        else next_state = S_WB;
      end
      S_MEM: begin
        d_ren = mem_rd;
        d_wen = !mem_rd;
        if (ctl.dhit) next_state = mem_rd ? S_WB : S_FETCH;
        else if (TO_EN && cnt == TO_LAST) begin
          err_set = 1'b1; next_state = S_HALT;
        end else begin
          wait_low = 1'b1;
        end
      end
      S_WB: begin
        reg_wr = 1'b1; next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // State, hit-wait counter and sticky halt/error flags.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= S_FETCH;
      cnt    <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      halt_q <= halt_q | (next_state == S_HALT);
      err_q  <= err_q | err_set;
      if (next_state != state) cnt <= '0;
      else if (TO_EN && wait_low) cnt <= cnt + 1'b1;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    ctl.PCWr = 1'b0; ctl.IRWr = 1'b0; ctl.RegWr = 1'b0; ctl.RegDst = 2'b00;
    ctl.ALUSrc = 2'b00; ctl.ExtOp = 1'b0; ctl.ALUop = 4'd0; ctl.iREN = 1'b0;
    ctl.dREN = 1'b0; ctl.dWEN = 1'b0; ctl.beq = 1'b0; ctl.bne = 1'b0; ctl.jump = 1'b0;
    ctl.jal = 1'b0; ctl.jr = 1'b0; ctl.lui = 1'b0; ctl.mem2reg = 1'b0; ctl.halt = 1'b0;
    ctl.mem_err = 1'b0; ctl.state_o = 3'd0;
    if (nRST) begin
      ctl.PCWr = pc_wr; ctl.IRWr = ir_wr; ctl.RegWr = reg_wr; ctl.RegDst = reg_dst;
      ctl.ALUSrc = alu_src; ctl.ExtOp = ext_op; ctl.ALUop = alu_op; ctl.iREN = i_ren;
      ctl.dREN = d_ren; ctl.dWEN = d_wen; ctl.beq = beq_s; ctl.bne = bne_s;
      ctl.jump = jump_s; ctl.jal = jal_s; ctl.jr = jr_s; ctl.lui = lui_sel;
      ctl.mem2reg = mem_rd; ctl.halt = halt_q; ctl.mem_err = err_q; ctl.state_o = state;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default-parameter instance plus a
// MEM_TIMEOUT=4 instance for the hit-wait timeout.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int failures = 0;

  multicycle_control_unit_if bus();
  multicycle_control_unit_if bus_to();

  multicycle_control_unit dut (.CLK(clk), .nRST(nrst), .ctl(bus));
  multicycle_control_unit #(.MEM_TIMEOUT(4)) dut_to (.CLK(clk), .nRST(nrst), .ctl(bus_to));

  always #5 clk = ~clk;

  // Advance one rising edge; return just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic ih,
                        input logic dh, input logic zr, input logic ov);
    bus.Instruct = op; bus.funct = fn; bus.ihit = ih; bus.dhit = dh;
    bus.zero = zr; bus.overflow = ov;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    set_in(6'h03, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.iREN !== 1'b0 || bus.RegDst !== 2'b00 || bus.state_o !== 3'd0 ||
        bus.PCWr !== 1'b0 || bus.IRWr !== 1'b0 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL reset_forced_zero iREN=%b RegDst=%b state=%0d PCWr=%b IRWr=%b halt=%b want all 0",
               bus.iREN, bus.RegDst, bus.state_o, bus.PCWr, bus.IRWr, bus.halt);
    end
    tick();
    nrst = 1'b1;
    bus.ihit = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 3'd0 || bus.iREN !== 1'b1 || bus.halt !== 1'b0 || bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release state=%0d iREN=%b halt=%b mem_err=%b want 0 1 0 0",
               bus.state_o, bus.iREN, bus.halt, bus.mem_err);
    end
  endtask

  task automatic test_addu();
    logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    set_in(6'h00, 6'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state_o !== exp_st[i] || bus.RegWr !== exp_rw[i]) begin
        failures++;
        $display("FAIL addu_cycle%0d state=%0d RegWr=%b want %0d %b",
                 i, bus.state_o, bus.RegWr, exp_st[i], exp_rw[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.RegDst !== 2'b01 || bus.ALUop !== 4'd2) begin
          failures++;
          $display("FAIL addu_wb_selects RegDst=%b ALUop=%0d want 01 2", bus.RegDst, bus.ALUop);
        end
      end
      tick();
    end
  endtask

  task automatic test_lw();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    int dren_cnt = 0;
    apply_reset();
    set_in(6'h23, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.dhit = (i == 6);
      #1;
      if (bus.dREN === 1'b1) dren_cnt++;
      checks++;
      if (bus.state_o !== exp_st[i]) begin
        failures++;
        $display("FAIL lw_cycle%0d state=%0d want %0d", i, bus.state_o, exp_st[i]);
      end
      if (i == 7) begin
        checks++;
        if (bus.RegWr !== 1'b1 || bus.mem2reg !== 1'b1 || bus.RegDst !== 2'b00) begin
          failures++;
          $display("FAIL lw_wb RegWr=%b mem2reg=%b RegDst=%b want 1 1 00",
                   bus.RegWr, bus.mem2reg, bus.RegDst);
        end
      end
      tick();
    end
    bus.dhit = 1'b0;
    #1;
    checks++;
    if (dren_cnt != 4 || bus.state_o !== 3'd0) begin
      failures++;
      $display("FAIL lw_latency dREN_cycles=%0d state=%0d want 4 0", dren_cnt, bus.state_o);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'h04, 6'h04, 6'h05};
    logic       zr  [3] = '{1'b1, 1'b0, 1'b0};
    logic       pcw [3] = '{1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 3; v++) begin
      apply_reset();
      set_in(ops[v], 6'h00, 1'b1, 1'b0, zr[v], 1'b0);
      tick();
      tick();
      #1;
      checks++;
      if (bus.state_o !== 3'd2 || bus.PCWr !== pcw[v] ||
          (bus.beq | bus.bne) !== 1'b1 || bus.RegWr !== 1'b0) begin
        failures++;
        $display("FAIL branch%0d_exec state=%0d PCWr=%b beq=%b bne=%b want 2 %b",
                 v, bus.state_o, bus.PCWr, bus.beq, bus.bne, pcw[v]);
      end
      tick();
      checks++;
      if (bus.state_o !== 3'd0) begin
        failures++;
        $display("FAIL branch%0d_return state=%0d want 0", v, bus.state_o);
      end
    end
  endtask

  task automatic test_jump();
    logic [5:0] ops [2] = '{6'h02, 6'h03};
    logic       ej  [2] = '{1'b1, 1'b0};
    logic       ejl [2] = '{1'b0, 1'b1};
    logic [1:0] edst [2] = '{2'b00, 2'b10};
    for (int v = 0; v < 2; v++) begin
      apply_reset();
      set_in(ops[v], 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      #1;
      checks++;
      if (bus.state_o !== 3'd1 || bus.jump !== ej[v] || bus.jal !== ejl[v] ||
          bus.RegWr !== ejl[v] || bus.PCWr !== 1'b1 || bus.RegDst !== edst[v]) begin
        failures++;
        $display("FAIL jump%0d_decode state=%0d jump=%b jal=%b RegWr=%b PCWr=%b RegDst=%b want 1 %b %b %b 1 %b",
                 v, bus.state_o, bus.jump, bus.jal, bus.RegWr, bus.PCWr, bus.RegDst,
                 ej[v], ejl[v], ejl[v], edst[v]);
      end
      tick();
      checks++;
      if (bus.state_o !== 3'd0) begin
        failures++;
        $display("FAIL jump%0d_return state=%0d want 0", v, bus.state_o);
      end
    end
  endtask

  task automatic test_overflow();
    int rw_seen = 0;
    apply_reset();
    set_in(6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.RegWr === 1'b1) rw_seen++;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      bus.ihit = i[0];
      bus.dhit = ~i[0];
      #1;
      if (bus.RegWr === 1'b1) rw_seen++;
      checks++;
      if (bus.state_o !== 3'd5 || bus.halt !== 1'b1 || bus.iREN !== 1'b0 ||
          bus.IRWr !== 1'b0 || bus.PCWr !== 1'b0) begin
        failures++;
        $display("FAIL ovf_halt%0d state=%0d halt=%b iREN=%b IRWr=%b PCWr=%b want 5 1 0 0 0",
                 i, bus.state_o, bus.halt, bus.iREN, bus.IRWr, bus.PCWr);
      end
      tick();
    end
    checks++;
    if (rw_seen != 0) begin
      failures++;
      $display("FAIL ovf_no_regwr RegWr_cycles=%0d want 0", rw_seen);
    end
    apply_reset();
    set_in(6'h00, 6'h21, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (bus.state_o !== 3'd4 || bus.RegWr !== 1'b1) begin
      failures++;
      $display("FAIL addu_ovf_ignored state=%0d RegWr=%b want 4 1", bus.state_o, bus.RegWr);
    end
  endtask

  task automatic test_timeout();
    bus_to.Instruct = 6'h00; bus_to.funct = 6'h21; bus_to.dhit = 1'b0;
    bus_to.zero = 1'b0; bus_to.overflow = 1'b0; bus_to.ihit = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus_to.state_o !== 3'd0 || bus_to.iREN !== 1'b1 || bus_to.mem_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d state=%0d iREN=%b mem_err=%b want 0 1 0",
                 i, bus_to.state_o, bus_to.iREN, bus_to.mem_err);
      end
      tick();
    end
    #1;
    checks++;
    if (bus_to.state_o !== 3'd5 || bus_to.mem_err !== 1'b1 || bus_to.halt !== 1'b1 ||
        bus_to.iREN !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fault state=%0d mem_err=%b halt=%b iREN=%b want 5 1 1 0",
               bus_to.state_o, bus_to.mem_err, bus_to.halt, bus_to.iREN);
    end
    apply_reset();
    tick();
    tick();
    tick();
    bus_to.ihit = 1'b1;
    #1;
    tick();
    bus_to.ihit = 1'b0;
    #1;
    checks++;
    if (bus_to.state_o !== 3'd1 || bus_to.mem_err !== 1'b0 || bus_to.halt !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hit_wins state=%0d mem_err=%b halt=%b want 1 0 0",
               bus_to.state_o, bus_to.mem_err, bus_to.halt);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    set_in(6'h3E, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checks++;
    if (bus.state_o !== 3'd5 || bus.halt !== 1'b1) begin
      failures++;
      $display("FAIL illegal_halt state=%0d halt=%b want 5 1", bus.state_o, bus.halt);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.halt !== 1'b0 || bus.state_o !== 3'd0) begin
      failures++;
      $display("FAIL halt_reset_forced halt=%b state=%0d want 0 0", bus.halt, bus.state_o);
    end
    tick();
    nrst = 1'b1;
    bus.Instruct = 6'h00;
    #1;
    checks++;
    if (bus.halt !== 1'b0 || bus.state_o !== 3'd0 || bus.iREN !== 1'b1) begin
      failures++;
      $display("FAIL halt_reset_exit halt=%b state=%0d iREN=%b want 0 0 1",
               bus.halt, bus.state_o, bus.iREN);
    end
  endtask

  task automatic test_reset_mid_sw();
    apply_reset();
    set_in(6'h2B, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (bus.state_o !== 3'd3 || bus.dWEN !== 1'b1 || bus.dREN !== 1'b0) begin
      failures++;
      $display("FAIL sw_mem state=%0d dWEN=%b dREN=%b want 3 1 0", bus.state_o, bus.dWEN, bus.dREN);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.dWEN !== 1'b0 || bus.state_o !== 3'd0) begin
      failures++;
      $display("FAIL sw_reset_abort dWEN=%b state=%0d want 0 0", bus.dWEN, bus.state_o);
    end
    tick();
    nrst = 1'b1;
    bus.ihit = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 3'd0 || bus.halt !== 1'b0 || bus.mem_err !== 1'b0 || bus.dWEN !== 1'b0) begin
      failures++;
      $display("FAIL sw_reset_exit state=%0d halt=%b mem_err=%b dWEN=%b want 0 0 0 0",
               bus.state_o, bus.halt, bus.mem_err, bus.dWEN);
    end
  endtask

  initial begin
    set_in(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_to.Instruct = 6'h00; bus_to.funct = 6'h00; bus_to.ihit = 1'b0;
    bus_to.dhit = 1'b0; bus_to.zero = 1'b0; bus_to.overflow = 1'b0;
    #1;
    test_reset();
    test_addu();
    test_lw();
    test_branch();
    test_jump();
    test_overflow();
    test_timeout();
    test_illegal();
    test_reset_mid_sw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
